// File: rtl/btn_debounce_if.sv
// Button debouncer bus: raw button levels in, debounced level and press strobe out.
interface btn_debounce_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;

    // Driver of the raw buttons and consumer of the cleaned outputs.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse
    );

    // The debouncer itself.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse
    );
endinterface

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer.
// Each channel has a 2-FF synchroniser, a stability counter and a 4-state FSM.
// btn_level is a registered, glitch-free debounced level. btn_pulse is a registered
// one-cycle strobe that fires once per accepted press and never while the button is held.
module btn_debounce #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.slave  bus
);

    // Derived from DEBOUNCE_CYCLES; not meant to be overridden.
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Terminal count: the CHK state is left here, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StPressChk   = 2'd1,
        StPressed    = 2'd2,
        StReleaseChk = 2'd3
    } state_e;

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;
    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] pulse_vec;

    // Two-stage synchroniser; the FSMs only ever look at s2_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.btn_raw;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             pulse_q;
        logic             pulse_d;

        // Channel state: FSM, stability counter and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        // Next state: a level must hold for DEBOUNCE_CYCLES+1 samples to be accepted.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    level_d = 1'b0;
                    if (s2_q[i]) begin
                        state_d = StPressChk;
                        cnt_d   = '0;
                    end
                end
                StPressChk: begin
                    if (!s2_q[i]) begin
                        state_d = StIdle;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StPressed;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                StPressed: begin
                    level_d = 1'b1;
                    if (!s2_q[i]) begin
                        state_d = StReleaseChk;
                        cnt_d   = '0;
                    end
                end
                StReleaseChk: begin
                    // A bounce back to 1 keeps the level high and emits no pulse.
                    if (s2_q[i]) begin
                        state_d = StPressed;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StIdle;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign level_vec[i] = level_q;
        assign pulse_vec[i] = pulse_q;
    end

    assign bus.btn_level = level_vec;
    assign bus.btn_pulse = pulse_vec;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES=8.
// Stimulus queues the expected output event (cycle, level, pulse); the monitor pops
// and compares whenever the outputs show a pulse or a level change.
module tb_btn_debounce;

    localparam int unsigned NB  = 4;
    localparam int unsigned DC  = 8;
    // Raw change before edge c+1 -> outputs updated after edge c+1+DC+2.
    localparam int          LAT = DC + 3;

    typedef struct {
        int         cyc;
        logic [3:0] level;
        logic [3:0] pulse;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];

    logic [3:0]  mon_prev;
    logic [3:0]  ds_prev = 4'b0000;
    logic [15:0] num     = 16'hABCD;
    logic        num_clr = 1'b0;

    btn_debounce_if #(.N_BTN(NB)) bus ();

    btn_debounce #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream hex-digit counter: btn[i] advances digit num[15-4i -: 4] on a rising level.
    always @(posedge clk) begin
        ds_prev <= bus.btn_level;
        if (num_clr) begin
            num <= 16'hABCD;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.btn_level[i] && !ds_prev[i]) begin
                    num[15-4*i -: 4] <= num[15-4*i -: 4] + 4'd1;
                end
            end
        end
    end

    // Monitor: compare every observable output event against the scoreboard.
    initial begin
        ev_t e;
        mon_prev = 4'b0000;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: got none, expected level %b pulse %b at cycle %0d",
                         e.level, e.pulse, e.cyc);
            end
            if (rst_n && (bus.btn_pulse != 4'b0000 || bus.btn_level != mon_prev)) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got level %b pulse %b at cycle %0d, expected none",
                             bus.btn_level, bus.btn_pulse, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.level !== bus.btn_level || e.pulse !== bus.btn_pulse) begin
                        errors++;
                        $display("FAIL event: got level %b pulse %b at cycle %0d, expected level %b pulse %b at cycle %0d",
                                 bus.btn_level, bus.btn_pulse, cyc, e.level, e.pulse, e.cyc);
                    end
                end
            end
            mon_prev = bus.btn_level;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive raw buttons now and queue the output event they must cause.
    task automatic drive_ev(input logic [3:0] raw, input logic [3:0] lvl, input logic [3:0] pls);
        ev_t e;
        bus.btn_raw = raw;
        e.cyc   = cyc + LAT;
        e.level = lvl;
        e.pulse = pls;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clr_num();
        num_clr = 1'b1;
        tick(1);
        num_clr = 1'b0;
    endtask

    // Stimulus
    initial begin
        bus.btn_raw = 4'b0000;
        #2;
        chk("reset_level_async", {12'h0, bus.btn_level}, 16'h0);
        chk("reset_pulse_async", {12'h0, bus.btn_pulse}, 16'h0);
        tick(3);
        chk("reset_level", {12'h0, bus.btn_level}, 16'h0);
        rst_n = 1'b1;
        tick(2);

        // 1: clean press and release on channel 0
        drive_ev(4'b0001, 4'b0001, 4'b0001);
        tick(14);
        drive_ev(4'b0000, 4'b0000, 4'b0000);
        tick(14);

        // 2: bouncy press on channel 1, only the final stable high is accepted
        bus.btn_raw = 4'b0010; tick(3);
        bus.btn_raw = 4'b0000; tick(3);
        bus.btn_raw = 4'b0010; tick(3);
        bus.btn_raw = 4'b0000; tick(3);
        drive_ev(4'b0010, 4'b0010, 4'b0010);
        tick(14);
        drive_ev(4'b0000, 4'b0000, 4'b0000);
        tick(14);

        // 3: release bounce on channel 2 keeps the level high
        drive_ev(4'b0100, 4'b0100, 4'b0100);
        tick(14);
        bus.btn_raw = 4'b0000; tick(5);
        bus.btn_raw = 4'b0100; tick(14);
        chk("release_bounce_level", {12'h0, bus.btn_level}, 16'h4);
        drive_ev(4'b0000, 4'b0000, 4'b0000);
        tick(14);

        // 4: all four pressed together
        clr_num();
        drive_ev(4'b1111, 4'b1111, 4'b1111);
        tick(14);
        chk("simul_level_held", {12'h0, bus.btn_level}, 16'hF);
        chk("simul_num", num, 16'hBCDE);
        drive_ev(4'b0000, 4'b0000, 4'b0000);
        tick(14);

        // 5: reset mid-debounce on channel 3 aborts the check
        bus.btn_raw = 4'b1000;
        tick(5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_level", {12'h0, bus.btn_level}, 16'h0);
        chk("rst_mid_pulse", {12'h0, bus.btn_pulse}, 16'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            ev_t e;
            e.cyc = cyc + LAT; e.level = 4'b1000; e.pulse = 4'b1000;
            sb.push_back(e);
        end
        tick(14);
        // Reset while accepted and held: outputs clear at once, then one new pulse.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_held_level", {12'h0, bus.btn_level}, 16'h0);
        chk("rst_held_pulse", {12'h0, bus.btn_pulse}, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            ev_t e;
            e.cyc = cyc + LAT; e.level = 4'b1000; e.pulse = 4'b1000;
            sb.push_back(e);
        end
        tick(14);
        drive_ev(4'b0000, 4'b0000, 4'b0000);
        tick(14);

        // 6: twenty clean presses on channel 0
        clr_num();
        for (int k = 0; k < 20; k++) begin
            drive_ev(4'b0001, 4'b0001, 4'b0001);
            tick(14);
            drive_ev(4'b0000, 4'b0000, 4'b0000);
            tick(14);
        end
        chk("repeat_num", num, 16'hEBCD);

        tick(2);
        chk("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
